alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 19, datapath width in bits.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 operation  input  5  operation code from alu_control.
REQ-006 a, b  input  WIDTH each  operands, sampled on accept.
REQ-007 ready  output  1  high in IDLE; start is accepted.
REQ-008 done  output  1  one-cycle pulse; result and flags valid.
REQ-009 result  output  WIDTH  primary result: sum, product low half or quotient.
REQ-010 result_hi  output  WIDTH  product high half, or remainder; 0 for other ops.
REQ-011 flags  output  4  {negative, overflow, carry, zero}.
REQ-012 err  output  1  illegal opcode or divide-by-zero, valid with done.

Function
REQ-013 Opcodes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SHL, 7 SHR (logical), 8 MUL (unsigned), 9 DIV (unsigned), 10 CMP; 11-31 illegal.
REQ-014 FSM SHALL have states IDLE, MUL, DIV, FIN; ready=1 only in IDLE.
REQ-015 Accept (start & ready) of ops 0-7, 10 or an illegal opcode SHALL go to FIN; done=1 on the next cycle (latency 1).
REQ-016 Accepting MUL SHALL enter MUL for exactly WIDTH shift-add iterations, then FIN; done asserts WIDTH+1 cycles after accept.
REQ-017 Accepting DIV SHALL enter DIV for exactly WIDTH restoring iterations, then FIN; same latency as MUL.
REQ-018 FIN SHALL assert done for one cycle and return to IDLE; back-to-back start is accepted on the following cycle.
REQ-019 start while not ready SHALL be ignored; operands SHALL come only from the accept cycle.
REQ-020 ADD/SUB: carry = carry-out (SUB: borrow); overflow = signed overflow; zero, negative from result.
REQ-021 CMP SHALL set flags exactly as SUB, with result = a.
REQ-022 Logic ops SHALL clear carry and overflow.
REQ-023 SHL/SHR amount SHALL be b[4:0]; amounts >= WIDTH yield 0; carry = last bit shifted out (0 if amount 0).
REQ-024 MUL: {result_hi,result} = 2*WIDTH-bit product; carry = overflow = (result_hi != 0).
REQ-025 DIV by b=0: result = all-ones, result_hi = a, err=1, flags zero=0, carry=overflow=0.
REQ-026 Illegal opcode: result = 0, result_hi = 0, flags = 0, err=1.
REQ-027 result, result_hi, flags, err SHALL hold their values until the next done.

Reset
REQ-028 rst_n low SHALL force IDLE, ready=1 once released, done=0, err=0, result=0, result_hi=0, flags=0.
REQ-029 Reset during MUL/DIV SHALL abort the operation without any done pulse.

Configuration
REQ-030 Macro ALU_MULDIV_EN SHALL compile in the MUL and DIV states and datapaths.
REQ-031 Without ALU_MULDIV_EN, opcodes 8 and 9 SHALL be treated as illegal per REQ-026, with latency 1.

Structure
REQ-032 Opcode constants, FSM state encoding and flag bit positions SHALL live in a shared package used also by alu_control.
REQ-033 The iterative multiply/divide engine SHALL be a sub-module alu_muldiv_iter (start, mode, operands in; done, hi, lo out).

Verification
REQ-034 ADD a=0x7FFFF, b=0x00001 -> done 1 cycle after accept, result=0, carry=1, zero=1, err=0.
REQ-035 MUL a=1000, b=700 -> done 20 cycles after accept, result=0x2AE60, result_hi=1, carry=1.
REQ-036 DIV a=100, b=7 -> result=14, result_hi=2, done 20 cycles after accept; DIV a=5, b=0 -> result=0x7FFFF, result_hi=5, err=1.
REQ-037 start pulsed with ADD at cycle 5 of a running MUL -> ignored; only the MUL done appears; a later ADD is accepted normally.
REQ-038 rst_n low at cycle 10 of a DIV -> no done, outputs zero, ready=1 after release.
REQ-039 Opcode 20, and opcode 8 built without ALU_MULDIV_EN -> done after 1 cycle, err=1, result=0.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// Shared opcode constants, FSM state encoding and flag bit positions for
// alu_multicycle and alu_control.
package alu_multicycle_pkg;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_NOT = 5'd5;
  localparam logic [4:0] OP_SHL = 5'd6;
  localparam logic [4:0] OP_SHR = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd8;
  localparam logic [4:0] OP_DIV = 5'd9;
  localparam logic [4:0] OP_CMP = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: master issues ops, slave (the ALU) answers.
interface alu_multicycle_if #(parameter int WIDTH = 19);
  logic             start;
  logic [4:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;
  logic             err;

  modport master (output start, operation, a, b,
                  input  ready, done, result, result_hi, flags, err);
  modport slave  (input  start, operation, a, b,
                  output ready, done, result, result_hi, flags, err);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: WIDTH shift-add multiply steps (mode=0) or restoring divide
// steps (mode=1). hi/lo show the post-step values; done flags the final step.
module alu_muldiv_iter #(parameter int WIDTH = 19) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             mode_q, busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   add, shf;
  logic [WIDTH-1:0] dif;
  logic             borrow;

  // hi/lo are combinational so the caller can latch the final step on the same edge
  always_comb begin
    add    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shf    = {hi_q, lo_q[WIDTH-1]};
    dif    = shf[WIDTH-1:0] - b_q;
    borrow = shf < {1'b0, b_q};
    if (mode_q) begin
      hi = borrow ? shf[WIDTH-1:0] : dif;
      lo = {lo_q[WIDTH-2:0], ~borrow};
    end else begin
      {hi, lo} = {add, lo_q[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= op_a;
      b_q    <= op_b;
      mode_q <= mode;
      cnt    <= CW'(WIDTH);
      busy   <= 1'b1;
    end else if (busy) begin
      hi_q <= hi;
      lo_q <= lo;
      cnt  <= cnt - CW'(1);
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops finish in one cycle; MUL/DIV use alu_muldiv_iter
// and are only compiled in when ALU_MULDIV_EN is defined (otherwise opcodes 8/9 are illegal).
module alu_multicycle
  import alu_multicycle_pkg::*;
#(parameter int WIDTH = 19) (
  input logic            clk,
  input logic            rst_n,
  alu_multicycle_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  state_t           state, state_nxt;
  logic             accept, long_op;
  logic [WIDTH-1:0] res_q, hi_q;
  logic [3:0]       flags_q;
  logic             err_q;
  logic [WIDTH-1:0] c_res, flag_src;
  logic             c_c, c_v, c_ill;
  logic [3:0]       c_flags;
  logic [WIDTH:0]   sum, dif, shl, shr;

  assign bus.ready     = (state == ST_IDLE);
  assign bus.done      = (state == ST_FIN);
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;
  assign accept        = bus.start && bus.ready;

  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    dif     = {1'b0, bus.a} - {1'b0, bus.b};
    shl     = {1'b0, bus.a} << bus.b[4:0];
    shr     = {bus.a, 1'b0} >> bus.b[4:0];
    c_res   = '0;
    c_c     = 1'b0;
    c_v     = 1'b0;
    c_ill   = 1'b0;
    long_op = 1'b0;
    case (bus.operation)
      OP_ADD: begin
        c_res = sum[MSB:0];
        c_c   = sum[WIDTH];
        c_v   = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        c_res = dif[MSB:0];
        c_c   = dif[WIDTH];
        c_v   = (bus.a[MSB] != bus.b[MSB]) && (dif[MSB] != bus.a[MSB]);
      end
      OP_AND: c_res = bus.a & bus.b;
      OP_OR:  c_res = bus.a | bus.b;
      OP_XOR: c_res = bus.a ^ bus.b;
      OP_NOT: c_res = ~bus.a;
      OP_SHL: {c_c, c_res} = shl;
      OP_SHR: {c_res, c_c} = shr;
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_DIV: long_op = 1'b1;
`endif
      default: c_ill = 1'b1;
    endcase
    // CMP reports the subtraction flags but returns a unchanged
    flag_src = c_res;
    if (bus.operation == OP_CMP) c_res = bus.a;
    c_flags = '0;
    if (!c_ill) begin
      c_flags[FLAG_N] = flag_src[MSB];
      c_flags[FLAG_V] = c_v;
      c_flags[FLAG_C] = c_c;
      c_flags[FLAG_Z] = (flag_src == '0);
    end
  end

`ifdef ALU_MULDIV_EN
  logic             eng_done, dz_q;
  logic [WIDTH-1:0] eng_hi, eng_lo;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && long_op),
    .mode  (bus.operation == OP_DIV),
    .op_a  (bus.a),
    .op_b  (bus.b),
    .done  (eng_done),
    .hi    (eng_hi),
    .lo    (eng_lo)
  );

  // restoring divide by zero naturally yields all-ones / a; only err needs remembering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dz_q <= 1'b0;
    else if (accept) dz_q <= (bus.b == '0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_FIN;
`ifdef ALU_MULDIV_EN
        if (bus.operation == OP_MUL)      state_nxt = ST_MUL;
        else if (bus.operation == OP_DIV) state_nxt = ST_DIV;
`endif
      end
`ifdef ALU_MULDIV_EN
      ST_MUL, ST_DIV: if (eng_done) state_nxt = ST_FIN;
`endif
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else if (accept && !long_op) begin
      res_q   <= c_res;
      hi_q    <= '0;
      flags_q <= c_flags;
      err_q   <= c_ill;
    end
`ifdef ALU_MULDIV_EN
    else if (eng_done) begin
      res_q           <= eng_lo;
      hi_q            <= eng_hi;
      err_q           <= (state == ST_DIV) && dz_q;
      flags_q[FLAG_N] <= eng_lo[MSB];
      flags_q[FLAG_V] <= (state == ST_MUL) && (eng_hi != '0);
      flags_q[FLAG_C] <= (state == ST_MUL) && (eng_hi != '0);
      flags_q[FLAG_Z] <= (state == ST_MUL) ? ({eng_hi, eng_lo} == '0) : (eng_lo == '0);
    end
`endif
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: arithmetic reference model plus
// per-cycle compare process; MUL/DIV vectors follow ALU_MULDIV_EN.
module tb_alu_multicycle;
  localparam int     W = 19;
  localparam longint M = longint'(2**W) - 1;
  localparam longint HALF = longint'(2**(W-1));

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flags;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   nc = 0;
  exp_t q[$];

  logic [W-1:0] last_res, last_hi;
  logic [3:0]   last_flags;
  logic         last_err;

  alu_multicycle_if #(.WIDTH(W)) bus ();
  alu_multicycle #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(string nm, longint act, longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, nc);
    end
  endtask

  function automatic exp_t model(int op, longint a, longint b);
    exp_t   e;
    longint r, fsrc, sa, sb, s, p;
    int     sh;
    logic   c, v, z;
    e.hi = '0; e.err = 1'b0; e.lat = 1; e.acc = 0;
    c = 1'b0; v = 1'b0; r = 0; p = 0;
    sa = (a >= HALF) ? a - (M + 1) : a;
    sb = (b >= HALF) ? b - (M + 1) : b;
    sh = int'(b & 31);
    case (op)
      0: begin r = (a + b) & M; c = (a + b) > M; s = sa + sb; v = (s >= HALF) || (s < -HALF); end
      1, 10: begin r = (a - b) & M; c = a < b; s = sa - sb; v = (s >= HALF) || (s < -HALF); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & M;
      6: begin
        r = (sh >= W) ? 0 : (a << sh) & M;
        c = (sh == 0 || sh > W) ? 1'b0 : logic'((a >> (W - sh)) & 1);
      end
      7: begin
        r = (sh >= W) ? 0 : a >> sh;
        c = (sh == 0 || sh > W) ? 1'b0 : logic'((a >> (sh - 1)) & 1);
      end
`ifdef ALU_MULDIV_EN
      8: begin
        p = a * b; r = p & M; e.hi = W'(p >> W);
        c = (p >> W) != 0; v = c; e.lat = W + 1;
      end
      9: begin
        if (b == 0) begin r = M; e.hi = W'(a); e.err = 1'b1; end
        else begin r = a / b; e.hi = W'(a % b); end
        e.lat = W + 1;
      end
`endif
      default: begin
        e.res = '0; e.flags = 4'b0000; e.err = 1'b1;
        return e;
      end
    endcase
    fsrc = r;
    z = (op == 8) ? (p == 0) : (r == 0);
    e.res = (op == 10) ? W'(a) : W'(r);
    e.flags = {logic'((fsrc >> (W - 1)) & 1), v, c, z};
    return e;
  endfunction

  // per-cycle compare: ready, done timing, payload on done, hold otherwise
  always @(negedge clk) begin : cmp
    exp_t e;
    nc++;
    if (!rst_n) begin
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_result_hi", bus.result_hi, 0);
      chk("rst_flags", bus.flags, 0);
      chk("rst_err", bus.err, 0);
      last_res = '0; last_hi = '0; last_flags = '0; last_err = 1'b0;
    end else begin
      chk("ready", bus.ready, q.size() == 0);
      if (bus.done) begin
        if (q.size() == 0) chk("done_unexpected", bus.done, 0);
        else begin
          e = q.pop_front();
          chk("latency", nc - e.acc, e.lat);
          chk("result", bus.result, e.res);
          chk("result_hi", bus.result_hi, e.hi);
          chk("flags", bus.flags, e.flags);
          chk("err", bus.err, e.err);
          last_res = bus.result; last_hi = bus.result_hi;
          last_flags = bus.flags; last_err = bus.err;
        end
      end else begin
        chk("hold_result", bus.result, last_res);
        chk("hold_result_hi", bus.result_hi, last_hi);
        chk("hold_flags", bus.flags, last_flags);
        chk("hold_err", bus.err, last_err);
        if (q.size() > 0 && nc - q[0].acc > q[0].lat) begin
          chk("done_timeout", bus.done, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 of the cycle after accept
  task automatic issue(int op, longint a, longint b);
    exp_t e;
    int   g = 0;
    while (!bus.ready && g < 200) begin @(posedge clk); #1; g++; end
    if (!bus.ready) begin chk("ready_timeout", bus.ready, 1); return; end
    bus.start = 1'b1; bus.operation = 5'(op); bus.a = W'(a); bus.b = W'(b);
    @(posedge clk);
    e = model(op, a, b);
    e.acc = nc;
    q.push_back(e);
    #1;
    bus.start = 1'b0; bus.a = ~bus.a; bus.b = ~bus.b;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (q.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    if (q.size() != 0) begin chk("idle_timeout", q.size(), 0); q.delete(); end
    while (!bus.ready && g < 100) begin @(posedge clk); #1; g++; end
  endtask

  task automatic lit(string nm, longint res, longint hi, longint fl, longint er);
    chk({nm, "_res"}, bus.result, res);
    chk({nm, "_hi"}, bus.result_hi, hi);
    chk({nm, "_flags"}, bus.flags, fl);
    chk({nm, "_err"}, bus.err, er);
  endtask

  localparam int NV = 18;
  int     vop[NV] = '{0, 1, 1, 10, 10, 2, 3, 4, 5, 6, 6, 6, 7, 7, 7, 7, 8, 9};
  longint va[NV]  = '{'h3FFFF, 3, 'h40000, 5, 2, 'h5A5A5, 'h12340, 'h7FFFF, 'hF,
                      'h40001, 1, 1, 3, 'h55555, 'h40000, 'h7FFFF, 'h7FFFF, 'h7FFFF};
  longint vb[NV]  = '{1, 5, 1, 5, 9, 'h0FF0F, 5, 'h7FFFF, 0,
                      1, 19, 25, 1, 0, 18, 35, 'h7FFFF, 3};

  initial begin
    exp_t e;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.operation = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // pin the model against hand-worked values
    e = model(0, 'h7FFFF, 1);
    chk("pin_add_res", e.res, 0);     chk("pin_add_flags", e.flags, 4'b0011);
    e = model(1, 3, 5);
    chk("pin_sub_res", e.res, 'h7FFFE); chk("pin_sub_flags", e.flags, 4'b1010);
    e = model(0, 'h3FFFF, 1);
    chk("pin_ovf_flags", e.flags, 4'b1100);
    e = model(6, 1, 19);
    chk("pin_shl_flags", e.flags, 4'b0011);
    e = model(20, 9, 9);
    chk("pin_ill_err", e.err, 1);     chk("pin_ill_res", e.res, 0);

    // carry-out wraps to zero
    issue(0, 'h7FFFF, 1); wait_idle();
    lit("add_wrap", 0, 0, 4'b0011, 0);

    // back-to-back vectors
    for (int i = 0; i < NV; i++) issue(vop[i], va[i], vb[i]);
    wait_idle();

    // start held through FIN must not be re-accepted with the new operands
    bus.start = 1'b1; bus.operation = 5'd0; bus.a = 19'd10; bus.b = 19'd20;
    @(posedge clk);
    e = model(0, 10, 20); e.acc = nc; q.push_back(e);
    #1 bus.a = 19'd1000; bus.b = 19'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle();
    lit("held_start", 30, 0, 4'b0000, 0);

`ifdef ALU_MULDIV_EN
    issue(8, 1000, 700); wait_idle();
    lit("mul", 'h2AE60, 1, 4'b0110, 0);
    issue(9, 100, 7); wait_idle();
    lit("div", 14, 2, 4'b0000, 0);
    issue(9, 5, 0); wait_idle();
    lit("div0", 'h7FFFF, 5, 4'b1000, 1);
    // ADD pulsed in cycle 5 of a running MUL is ignored
    issue(8, 1000, 700);
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1; bus.operation = 5'd0; bus.a = 19'd1; bus.b = 19'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle();
    issue(0, 2, 3); wait_idle();
    lit("after_mul_add", 5, 0, 4'b0000, 0);
`else
    issue(8, 1000, 700); wait_idle();
    lit("mul_illegal", 0, 0, 4'b0000, 1);
    issue(9, 100, 7); wait_idle();
    lit("div_illegal", 0, 0, 4'b0000, 1);
`endif
    issue(20, 'h12345, 'h54321); wait_idle();
    lit("op20", 0, 0, 4'b0000, 1);

    // reset mid-operation: no done, outputs cleared, ready after release
    issue(3, 'h00F0F, 'h70000); wait_idle();
`ifdef ALU_MULDIV_EN
    issue(9, 100, 7);
    repeat (8) @(posedge clk);
`endif
    #1 rst_n = 1'b0; q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lit("post_rst", 0, 0, 4'b0000, 0);
    chk("post_rst_ready", bus.ready, 1);
    repeat (3) @(posedge clk);
    #1;
    issue(1, 'h40000, 1); wait_idle();
    lit("post_rst_sub", 'h3FFFF, 0, 4'b0100, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
